// File: rtl/uart_operand_rx.sv
// uart_operand_rx: 8N1 UART receiver that splits each good byte into two 4-bit multiplier operands.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   rx        - asynchronous serial input, idle high
//   op_a      - registered operand A, byte[3:0]
//   op_b      - registered operand B, byte[7:4]
//   op_valid  - one-cycle pulse when new operands are loaded
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   busy      - high whenever the receiver is not idle
module uart_operand_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       op_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic rx_m, rx_s;
    logic bit_end, half_end;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign half_end = cnt == CW'(HALF - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            op_a <= '0;
            op_b <= '0;
            op_valid <= 1'b0;
            frame_err <= 1'b0;
            busy <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            op_valid <= 1'b0;
            frame_err <= 1'b0;
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy <= 1'b1;
                    end
                end
                START: if (half_end) begin
                    cnt <= '0;
                    state <= rx_s ? IDLE : DATA;
                    busy <= !rx_s;
                end
                DATA: if (bit_end) begin
                    cnt <= '0;
                    shreg <= {rx_s, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state <= STOP;
                end
                STOP: if (bit_end) begin
                    cnt <= '0;
                    if (rx_s) begin
                        op_a <= shreg[3:0];
                        op_b <= shreg[7:4];
                        op_valid <= 1'b1;
                        state <= IDLE;
                        busy <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_operand_rx.sv
// tb_uart_operand_rx: directed and randomized frame checks of uart_operand_rx at 8, 4 and 104 clocks per bit.
module tb_uart_operand_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx8 = 1'b1, rx4 = 1'b1, rx104 = 1'b1;
    logic [3:0] op_a8, op_b8, op_a4, op_b4, op_a104, op_b104;
    logic op_valid8, frame_err8, busy8, op_valid4, frame_err4, busy4, op_valid104, frame_err104, busy104;
    int checks = 0, errors = 0;
    int cyc = 0;
    int nv8 = 0, nf8 = 0, nv4 = 0, nf4 = 0, nv104 = 0, nf104 = 0, ovl = 0, bsy8 = 0;
    int vcyc8 = 0, vprev8 = 0;

    uart_operand_rx #(.CLKS_PER_BIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .rx(rx8), .op_a(op_a8), .op_b(op_b8),
        .op_valid(op_valid8), .frame_err(frame_err8), .busy(busy8));
    uart_operand_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx(rx4), .op_a(op_a4), .op_b(op_b4),
        .op_valid(op_valid4), .frame_err(frame_err4), .busy(busy4));
    uart_operand_rx #(.CLKS_PER_BIT(104)) dut104 (
        .clk(clk), .rst_n(rst_n), .rx(rx104), .op_a(op_a104), .op_b(op_b104),
        .op_valid(op_valid104), .frame_err(frame_err104), .busy(busy104));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (op_valid8) begin
            nv8++;
            vprev8 = vcyc8;
            vcyc8 = cyc;
        end
        if (frame_err8) nf8++;
        if (op_valid4) nv4++;
        if (frame_err4) nf4++;
        if (op_valid104) nv104++;
        if (frame_err104) nf104++;
        if (busy8) bsy8++;
        if ((op_valid8 && frame_err8) || (op_valid4 && frame_err4) || (op_valid104 && frame_err104)) ovl++;
    end

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cpb(int d);
        return d == 0 ? 8 : d == 1 ? 4 : 104;
    endfunction

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(int d, logic v);
        case (d)
            0: rx8 = v;
            1: rx4 = v;
            default: rx104 = v;
        endcase
    endtask

    // Pin level is left at the stop-bit value afterwards.
    task automatic send(int d, logic [7:0] b, logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_rx(d, f[i]);
            idle(cpb(d));
        end
    endtask

    initial begin
        int t, v0, f0, b0, lat;
        logic [7:0] b;
        logic [9:0] fr;
        idle(3);
        chk("rst_op_a", op_a8, 0);
        chk("rst_op_b", op_b8, 0);
        chk("rst_op_valid", op_valid8, 0);
        chk("rst_frame_err", frame_err8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_busy4", busy4, 0);
        rst_n = 1'b1;
        idle(5);

        // Single frame 0x3A.
        t = cyc;
        send(0, 8'h3A, 1'b1);
        idle(16);
        chk("f3a_count", nv8, 1);
        chk("f3a_op_a", op_a8, 8'h3A % 16);
        chk("f3a_op_b", op_b8, 8'h3A / 16);
        chk("f3a_prod", int'(op_a8) * int'(op_b8), 'h1E);
        chk("f3a_ferr", nf8, 0);
        lat = vcyc8 - t - (3 + 4 + 9 * 8);
        chk("f3a_latency", int'(lat >= -1 && lat <= 1), 1);

        // Back-to-back 0xFF then 0x00.
        v0 = nv8;
        send(0, 8'hFF, 1'b1);
        chk("bb_ff_op_a", op_a8, 15);
        chk("bb_ff_op_b", op_b8, 15);
        chk("bb_ff_prod", int'(op_a8) * int'(op_b8), 'hE1);
        send(0, 8'h00, 1'b1);
        idle(16);
        chk("bb_count", nv8 - v0, 2);
        chk("bb_spacing", vcyc8 - vprev8, 80);
        chk("bb_00_op_a", op_a8, 0);
        chk("bb_00_op_b", op_b8, 0);
        chk("bb_00_prod", int'(op_a8) * int'(op_b8), 0);

        // Two-cycle glitch.
        v0 = nv8;
        f0 = nf8;
        b0 = bsy8;
        set_rx(0, 1'b0);
        idle(2);
        set_rx(0, 1'b1);
        idle(20);
        chk("glitch_valid", nv8 - v0, 0);
        chk("glitch_ferr", nf8 - f0, 0);
        chk("glitch_busy_len", bsy8 - b0, 4);
        chk("glitch_busy_end", busy8, 0);

        // Framing error then held break.
        v0 = nv8;
        f0 = nf8;
        send(0, 8'h5C, 1'b0);
        idle(40);
        chk("ferr_count", nf8 - f0, 1);
        chk("ferr_valid", nv8 - v0, 0);
        chk("ferr_op_a", op_a8, 0);
        chk("ferr_op_b", op_b8, 0);
        chk("ferr_waiting", busy8, 1);
        set_rx(0, 1'b1);
        idle(16);
        chk("ferr_released", busy8, 0);
        send(0, 8'h21, 1'b1);
        idle(16);
        chk("f21_op_a", op_a8, 1);
        chk("f21_op_b", op_b8, 2);
        chk("f21_count", nv8 - v0, 1);
        chk("f21_ferr", nf8 - f0, 1);

        // Reset during data bit 4 of 0x77.
        v0 = nv8;
        f0 = nf8;
        fr = {1'b1, 8'h77, 1'b0};
        for (int i = 0; i < 5; i++) begin
            set_rx(0, fr[i]);
            idle(8);
        end
        set_rx(0, fr[5]);
        idle(4);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_op_a", op_a8, 0);
        chk("mrst_op_b", op_b8, 0);
        chk("mrst_busy", busy8, 0);
        chk("mrst_valid", op_valid8, 0);
        chk("mrst_ferr", frame_err8, 0);
        @(negedge clk);
        set_rx(0, 1'b1);
        idle(4);
        rst_n = 1'b1;
        idle(8);
        chk("mrst_no_valid", nv8 - v0, 0);
        chk("mrst_no_ferr", nf8 - f0, 0);
        send(0, 8'h77, 1'b1);
        idle(16);
        chk("f77_op_a", op_a8, 7);
        chk("f77_op_b", op_b8, 7);
        chk("f77_count", nv8 - v0, 1);

        // Random bytes at 8 clocks per bit.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            v0 = nv8;
            send(0, b, 1'b1);
            idle(4);
            chk("rnd8_op_a", op_a8, b % 16);
            chk("rnd8_op_b", op_b8, b / 16);
            chk("rnd8_count", nv8 - v0, 1);
        end

        // Full sweep at 4 clocks per bit.
        for (int i = 0; i < 256; i++) begin
            v0 = nv4;
            send(1, 8'(i), 1'b1);
            idle(8);
            chk("sw4_op_a", op_a4, i % 16);
            chk("sw4_op_b", op_b4, i / 16);
            chk("sw4_count", nv4 - v0, 1);
        end

        // Random subset at 104 clocks per bit.
        for (int i = 0; i < 16; i++) begin
            b = i == 0 ? 8'h00 : i == 1 ? 8'hFF : 8'($urandom);
            v0 = nv104;
            send(2, b, 1'b1);
            idle(104);
            chk("sw104_op_a", op_a104, b % 16);
            chk("sw104_op_b", op_b104, b / 16);
            chk("sw104_count", nv104 - v0, 1);
        end

        chk("no_overlap", ovl, 0);
        chk("ferr4_none", nf4, 0);
        chk("ferr104_none", nf104, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
